fp32_add_seq: RTL and testbench



---
 rtl/fpu_pkg.sv | 23 ++
 rtl/fp32_unpack.sv | 38 +++
 rtl/fp32_add_seq.sv | 209 ++++++++++++++++++++
 tb/tb_fp32_add_seq.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types and constants for the binary32 adder.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam int          EXP_BIAS = 127;
    localparam int          EXP_MAX  = 255;
    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE, ALIGN, ADD, NORM, ROUND, DONE
    } add_state_t;

    typedef enum logic [2:0] {
        CLS_ZERO, CLS_SUB, CLS_NORM, CLS_INF, CLS_NAN
    } fp_class_t;

endpackage

// File: rtl/fp32_unpack.sv
// Operand classification and hidden-bit insertion.
// FP32_ADD_SUBNORMAL_EN keeps subnormals; otherwise they read as zero.
module fp32_unpack
    import fpu_pkg::*;
(
    input  logic [31:0] op,
    output fp_class_t   cls,
    output logic        sign,
    output logic [9:0]  exp,
    output logic [23:0] man
);

    fp32_t f;
    assign f = fp32_t'(op);

    always_comb begin
        sign = f.sign;
        exp  = {2'b00, f.exp};
        man  = {1'b1, f.frac};
        cls  = CLS_NORM;
        if (f.exp == 8'hFF) begin
            cls = (f.frac == '0) ? CLS_INF : CLS_NAN;
        end else if (f.exp == 8'h00) begin
            exp = 10'd1;
            man = {1'b0, f.frac};
            if (f.frac == '0) begin
                cls = CLS_ZERO;
            end else begin
`ifdef FP32_ADD_SUBNORMAL_EN
                cls = CLS_SUB;
`else
                cls = CLS_ZERO;
`endif
            end
        end
    end

endmodule

// File: rtl/fp32_add_seq.sv
// Multi-cycle binary32 adder, RNE, serial aligner.
// Define FP32_ADD_SUBNORMAL_EN for subnormal support (else flush-to-zero).
module fp32_add_seq
    import fpu_pkg::*;
#(
    parameter int MAX_ALIGN = 27
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [2:0]  flags
);

    localparam logic [9:0] MAX_A10 = 10'(MAX_ALIGN);
    localparam logic [4:0] MAX_A5  = 5'(MAX_ALIGN);
    localparam logic [9:0] EMAX10  = 10'(EXP_MAX);

    add_state_t  state, state_n;
    fp_class_t   cls_a, cls_b;
    logic        sa, sb;
    logic [9:0]  ea, eb;
    logic [23:0] ma, mb;

    logic        l_sign, s_sign, r_sign, special;
    logic [9:0]  l_exp, e;
    logic [26:0] l_man, s_man;
    logic [27:0] m;
    logic [4:0]  cnt;
    logic [31:0] spec_res;
    logic [2:0]  spec_flg;

    fp32_unpack u_unpack_a (.op(op_a), .cls(cls_a), .sign(sa), .exp(ea), .man(ma));
    fp32_unpack u_unpack_b (.op(op_b), .cls(cls_b), .sign(sb), .exp(eb), .man(mb));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    logic        a_big;
    logic [9:0]  diff;
    logic [4:0]  cnt0;
    assign a_big = (ea >= eb);
    assign diff  = a_big ? ea - eb : eb - ea;
    assign cnt0  = (diff > MAX_A10) ? MAX_A5 : diff[4:0];

    logic        sp;
    logic [31:0] sp_res;
    logic [2:0]  sp_flg;
    always_comb begin
        sp     = 1'b1;
        sp_res = '0;
        sp_flg = '0;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            sp_res = QNAN;
            sp_flg = 3'b100;
        end else if (cls_a == CLS_INF && cls_b == CLS_INF && sa != sb) begin
            sp_res = QNAN;
            sp_flg = 3'b100;
        end else if (cls_a == CLS_INF) begin
            sp_res = {sa, POS_INF[30:0]};
        end else if (cls_b == CLS_INF) begin
            sp_res = {sb, POS_INF[30:0]};
        end else if (cls_a == CLS_ZERO && cls_b == CLS_ZERO) begin
            sp_res = {sa & sb, 31'b0};
        end else if (cls_a == CLS_ZERO) begin
            sp_res = op_b;
        end else if (cls_b == CLS_ZERO) begin
            sp_res = op_a;
        end else begin
            sp = 1'b0;
        end
    end

    // Unlike signs: the anchor may still be the smaller magnitude when exps tie.
    logic        same, l_ge, sum_sign;
    logic [27:0] sum;
    assign same     = (l_sign == s_sign);
    assign l_ge     = (l_man >= s_man);
    assign sum      = same ? {1'b0, l_man} + {1'b0, s_man}
                    : l_ge ? {1'b0, l_man} - {1'b0, s_man}
                    :        {1'b0, s_man} - {1'b0, l_man};
    assign sum_sign = (same || l_ge) ? l_sign : s_sign;

    logic        inc, inexact, hid;
    logic [24:0] rnd;
    logic [22:0] frac;
    logic [9:0]  e_r;
    logic [31:0] rnd_res;
    logic [2:0]  rnd_flg;
    always_comb begin
        inexact = |m[2:0];
        inc     = m[2] & (m[3] | m[1] | m[0]);
        rnd     = {1'b0, m[26:3]} + {24'b0, inc};
        if (rnd[24]) begin
            frac = rnd[23:1];
            hid  = 1'b1;
            e_r  = e + 10'd1;
        end else begin
            frac = rnd[22:0];
            hid  = rnd[23];
            e_r  = e;
        end
        rnd_res = {r_sign, e_r[7:0], frac};
        rnd_flg = {2'b00, inexact};
        if (e_r >= EMAX10) begin
            rnd_res = {r_sign, POS_INF[30:0]};
            rnd_flg = 3'b011;
        end else if (!hid) begin
`ifdef FP32_ADD_SUBNORMAL_EN
            rnd_res = {r_sign, 8'h00, frac};
`else
            rnd_res = {r_sign, 31'b0};
            rnd_flg = 3'b001;
`endif
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (in_valid) state_n = sp ? ADD : ALIGN;
            ALIGN: if (cnt <= 5'd1) state_n = ADD;
            ADD: begin
                if (special)                state_n = ROUND;
                else if (sum == '0)         state_n = DONE;
                else if (sum[27] || !sum[26]) state_n = NORM;
                else                        state_n = ROUND;
            end
            NORM: begin
                if (m[27] || m[26] || e == 10'd1) state_n = ROUND;
                else if (m[25] || e == 10'd2)     state_n = ROUND;
            end
            ROUND: state_n = DONE;
            DONE:  if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            l_sign   <= 1'b0;
            s_sign   <= 1'b0;
            r_sign   <= 1'b0;
            special  <= 1'b0;
            l_exp    <= '0;
            e        <= '0;
            l_man    <= '0;
            s_man    <= '0;
            m        <= '0;
            cnt      <= '0;
            spec_res <= '0;
            spec_flg <= '0;
            result   <= '0;
            flags    <= '0;
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    special  <= sp;
                    spec_res <= sp_res;
                    spec_flg <= sp_flg;
                    cnt      <= cnt0;
                    l_sign   <= a_big ? sa : sb;
                    s_sign   <= a_big ? sb : sa;
                    l_exp    <= a_big ? ea : eb;
                    l_man    <= a_big ? {ma, 3'b000} : {mb, 3'b000};
                    s_man    <= a_big ? {mb, 3'b000} : {ma, 3'b000};
                end
                ALIGN: if (cnt != '0) begin
                    s_man <= {1'b0, s_man[26:2], s_man[1] | s_man[0]};
                    cnt   <= cnt - 5'd1;
                end
                ADD: begin
                    m      <= sum;
                    e      <= l_exp;
                    r_sign <= sum_sign;
                    if (!special && sum == '0) begin
                        result <= '0;
                        flags  <= '0;
                    end
                end
                NORM: begin
                    if (m[27]) begin
                        m <= {1'b0, m[27:2], m[1] | m[0]};
                        e <= e + 10'd1;
                    end else if (!m[26] && e != 10'd1) begin
                        m <= {m[26:0], 1'b0};
                        e <= e - 10'd1;
                    end
                end
                ROUND: begin
                    result <= special ? spec_res : rnd_res;
                    flags  <= special ? spec_flg : rnd_flg;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_add_seq.sv
// Directed-vector bench for fp32_add_seq.
module tb_fp32_add_seq;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        in_ready, out_valid;
    logic [31:0] result;
    logic [2:0]  flags;

    int checks = 0;
    int errors = 0;

    fp32_add_seq dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [2:0] f, output int lat);
        @(negedge CLK);
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge CLK);
            #1 lat++;
        end
        r = result;
        f = flags;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout a=%h b=%h", a, b);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        logic [2:0]  f;
        int          lat;
        int          n;

        vecs.push_back('{32'h3F800000, 32'h40000000, 32'h40400000, 3'b000, 3});
        vecs.push_back('{32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000, -1});
        vecs.push_back('{32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100, 2});
        vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011, 4});
        vecs.push_back('{32'h3F800000, 32'h33800000, 32'h3F800000, 3'b001, -1});
        vecs.push_back('{32'h3F800001, 32'h33800000, 32'h3F800002, 3'b001, -1});
        vecs.push_back('{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3'b100, 2});
        vecs.push_back('{32'h3F800000, 32'h7F800001, 32'h7FC00000, 3'b100, 2});
        vecs.push_back('{32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b000, 2});
        vecs.push_back('{32'h40A00000, 32'hFF800000, 32'hFF800000, 3'b000, 2});
        vecs.push_back('{32'h00000000, 32'h40490FDB, 32'h40490FDB, 3'b000, 2});
        vecs.push_back('{32'h80000000, 32'h80000000, 32'h80000000, 3'b000, 2});
        vecs.push_back('{32'h00000000, 32'h80000000, 32'h00000000, 3'b000, 2});
        vecs.push_back('{32'h40400000, 32'hBF800000, 32'h40000000, 3'b000, -1});
        vecs.push_back('{32'h3F800000, 32'hBFC00000, 32'hBF000000, 3'b000, -1});
        vecs.push_back('{32'h3F800000, 32'h53800000, 32'h53800000, 3'b001, -1});
        vecs.push_back('{32'h3F7FFFFF, 32'h33800000, 32'h3F800000, 3'b000, -1});
        vecs.push_back('{32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 3'b001, -1});
`ifdef FP32_ADD_SUBNORMAL_EN
        vecs.push_back('{32'h00000001, 32'h00000001, 32'h00000002, 3'b000, -1});
        vecs.push_back('{32'h00C00000, 32'h80800000, 32'h00400000, 3'b000, -1});
`else
        vecs.push_back('{32'h00000001, 32'h00000001, 32'h00000000, 3'b000, 2});
        vecs.push_back('{32'h00C00000, 32'h80800000, 32'h00000000, 3'b001, -1});
`endif

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_result", result, 32'h0);
        chk("rst_flags", {29'b0, flags}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].a, vecs[i].b, r, f, lat);
            chk($sformatf("v%0d_result", i), r, vecs[i].res);
            chk($sformatf("v%0d_flags", i), {29'b0, f}, {29'b0, vecs[i].flg});
            if (vecs[i].lat >= 0)
                chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        end

        // Backpressure: result held, new operands refused while DONE
        @(negedge CLK);
        op_a = 32'h3F800000;
        op_b = 32'h40000000;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge CLK);
            #1 n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            op_a = 32'h7F800000;
            op_b = 32'hFF800000;
            in_valid = 1'b1;
            @(posedge CLK);
            #1 in_valid = 1'b0;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_result", result, 32'h40400000);
            chk("bp_flags", {29'b0, flags}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge CLK);
        #1 out_ready = 1'b0;
        chk("bp_ack_out_valid", {31'b0, out_valid}, 32'd0);
        chk("bp_ack_in_ready", {31'b0, in_ready}, 32'd1);
        repeat (3) @(posedge CLK);
        #1 chk("bp_pulse_ignored", {31'b0, out_valid}, 32'd0);

        // Reset while aligning a 23-place shift
        @(negedge CLK);
        op_a = 32'h4B000000;
        op_b = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge CLK);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge CLK);
        #1 chk("mid_busy_in_ready", {31'b0, in_ready}, 32'd0);
        nRST = 1'b0;
        #1;
        chk("rst_async_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_async_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge CLK);
        #1 chk("rst_next_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_next_out_valid", {31'b0, out_valid}, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        repeat (30) @(posedge CLK);
        #1 chk("rst_discarded", {31'b0, out_valid}, 32'd0);
        do_op(32'h3F800000, 32'h40000000, r, f, lat);
        chk("post_rst_result", r, 32'h40400000);
        chk("post_rst_latency", lat, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
